apb_uart_regif: RTL

APB_UART_REGIF -- requirements
Module: apb_uart_regif

---
 rtl/apb_uart_regif.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_uart_regif.sv
// ---------------------------------------------------------------------------
// apb_uart_regif
//
// APB slave front end for a UART register block. It captures one APB transfer,
// decodes the captured address into a single request pulse toward the UART,
// waits for the UART to complete, then returns a registered APB response.
//
// Optional feature macro: APB_TIMEOUT_EN
//   defined   : WAIT is bounded by TIMEOUT_CYCLES. On expiry the transfer
//               completes with PSLVERR=1 and PRDATA=0.
//   undefined : WAIT lasts until uart_ready. TIMEOUT_CYCLES has no effect.
//
// Ports
//   PCLK, PRESET            clock, asynchronous active-high reset
//   PSELx, PENABLE, PWRITE  APB control from the master
//   PADDR, PWDATA           APB address and write data
//   PRDATA, PREADY, PSLVERR registered APB response
//   tx_req, rx_req          one-cycle pulses: transmit write / receive read
//   cfg_wr_req, cfg_rd_req  one-cycle pulses: config register write / read
//   req_addr, req_wdata     captured address/data, stable from ISSUE until IDLE
//   uart_rdata, uart_ready,
//   uart_error              UART completion handshake
//
// Register map (byte addresses, exact match, all other addresses unmapped):
//   trans_data 0x00 (W)   recv_data 0x04 (R)
//   baud_config 0x08, frame_config 0x0C, parity_config 0x10,
//   stop_bits_config 0x14 (R/W)
// ---------------------------------------------------------------------------
`ifndef UART_ADDR_TRANS_DATA
  `define UART_ADDR_TRANS_DATA       32'h0000_0000
`endif
`ifndef UART_ADDR_RECV_DATA
  `define UART_ADDR_RECV_DATA        32'h0000_0004
`endif
`ifndef UART_ADDR_BAUD_CONFIG
  `define UART_ADDR_BAUD_CONFIG      32'h0000_0008
`endif
`ifndef UART_ADDR_FRAME_CONFIG
  `define UART_ADDR_FRAME_CONFIG     32'h0000_000C
`endif
`ifndef UART_ADDR_PARITY_CONFIG
  `define UART_ADDR_PARITY_CONFIG    32'h0000_0010
`endif
`ifndef UART_ADDR_STOP_BITS_CONFIG
  `define UART_ADDR_STOP_BITS_CONFIG 32'h0000_0014
`endif

module apb_uart_regif #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  tx_req,
  output logic                  rx_req,
  output logic                  cfg_wr_req,
  output logic                  cfg_rd_req,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] uart_rdata,
  input  logic                  uart_ready,
  input  logic                  uart_error
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state, state_nxt;

  logic req_write;
  logic setup;

  // Address decode of the captured transfer
  logic hit_tx, hit_rx, hit_cfg;
  logic sel_tx, sel_rx, sel_cw, sel_cr, legal;

  // Completion controls produced by the next-state logic
  logic                  cpl;
  logic                  cpl_err;
  logic                  rdata_load;
  logic [DATA_WIDTH-1:0] rdata_val;
  logic                  tmo_hit;

  assign setup = PSELx && !PENABLE;

  assign hit_tx  = (req_addr == ADDR_WIDTH'(`UART_ADDR_TRANS_DATA));
  assign hit_rx  = (req_addr == ADDR_WIDTH'(`UART_ADDR_RECV_DATA));
  assign hit_cfg = (req_addr == ADDR_WIDTH'(`UART_ADDR_BAUD_CONFIG))   ||
                   (req_addr == ADDR_WIDTH'(`UART_ADDR_FRAME_CONFIG))  ||
                   (req_addr == ADDR_WIDTH'(`UART_ADDR_PARITY_CONFIG)) ||
                   (req_addr == ADDR_WIDTH'(`UART_ADDR_STOP_BITS_CONFIG));

  // trans_data is write-only and recv_data is read-only; the wrong direction
  // is treated like an unmapped address.
  assign sel_tx = hit_tx  &&  req_write;
  assign sel_rx = hit_rx  && !req_write;
  assign sel_cw = hit_cfg &&  req_write;
  assign sel_cr = hit_cfg && !req_write;
  assign legal  = sel_tx || sel_rx || sel_cw || sel_cr;

  // Requests are decoded from registered state and captured address, so they
  // are exactly one ISSUE cycle wide and clear asynchronously with reset.
  assign tx_req     = (state == ISSUE) && sel_tx;
  assign rx_req     = (state == ISSUE) && sel_rx;
  assign cfg_wr_req = (state == ISSUE) && sel_cw;
  assign cfg_rd_req = (state == ISSUE) && sel_cr;

`ifdef APB_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Counter reads k-1 during the k-th WAIT cycle since it sits at zero
  // outside WAIT; hitting TIMEOUT_CYCLES-1 means this is the last WAIT cycle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)              tmo_cnt <= '0;
    else if (state == WAIT)  tmo_cnt <= tmo_cnt + 8'd1;
    else                     tmo_cnt <= '0;
  end

  assign tmo_hit = (state == WAIT) && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  // No timeout hardware in this build; TIMEOUT_CYCLES is deliberately unused.
  logic [7:0] unused_tmo;
  assign unused_tmo = 8'(TIMEOUT_CYCLES);
  assign tmo_hit    = 1'b0;
`endif

  // Next-state and completion decisions
  always_comb begin
    state_nxt  = state;
    cpl        = 1'b0;
    cpl_err    = 1'b0;
    rdata_load = 1'b0;
    rdata_val  = '0;
    case (state)
      IDLE: begin
        if (setup) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (!PSELx) begin
          state_nxt = IDLE;                 // master abandoned the transfer
        end else if (legal) begin
          state_nxt = WAIT;
        end else begin
          state_nxt  = DONE;                // decode error: no UART request
          cpl        = 1'b1;
          cpl_err    = 1'b1;
          rdata_load = 1'b1;
        end
      end
      WAIT: begin
        if (!PSELx) begin
          state_nxt = IDLE;
        end else if (uart_ready) begin
          state_nxt  = DONE;
          cpl        = 1'b1;
          cpl_err    = uart_error;
          rdata_load = !req_write;
          rdata_val  = uart_rdata;
        end else if (tmo_hit) begin
          state_nxt  = DONE;
          cpl        = 1'b1;
          cpl_err    = 1'b1;
          rdata_load = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      PRDATA    <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_write <= 1'b0;
    end else begin
      state  <= state_nxt;
      PREADY <= cpl;                       // high only in the DONE cycle
      if (cpl)        PSLVERR <= cpl_err;
      if (rdata_load) PRDATA  <= rdata_val;
      if ((state == IDLE) && setup) begin
        req_addr  <= PADDR;
        req_wdata <= PWDATA;
        req_write <= PWRITE;
      end
    end
  end

endmodule
